dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
// - Shares one single-port data memory between the pipelined MIPS core's
//   MEM-stage port (cpu_*) and a debug/loader port (dbg_*).
// - Sits between the core and dmem inside top.
// - Holds the core via cpu_stall until its access completes.
// - A watchdog aborts accesses the memory never acknowledges.
// PARAMETERS
// - AW        32  address width, byte address
// - DW        32  data width
// - MAX_WAIT  16  cycles a granted access may wait for mem_ready before abort; must be >=1
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   synchronous, active-high
// - cpu_req    in   1   core load/store request; held with its fields until !cpu_stall
// - cpu_we     in   1   1=store, 0=load
// - cpu_addr   in   AW  core address
// - cpu_wdata  in   DW  core store data
// - cpu_rdata  out  DW  load data; valid in the cycle cpu_stall falls
// - cpu_stall  out  1   comb: cpu_req & !(cpu_done this cycle)
// - dbg_req    in   1   debug request; held until dbg_ack
// - dbg_we     in   1   1=write, 0=read
// - dbg_addr   in   AW  debug address
// - dbg_wdata  in   DW  debug write data
// - dbg_rdata  out  DW  debug read data; valid with dbg_ack
// - dbg_ack    out  1   one-cycle completion pulse
// - mem_req    out  1   registered; memory access active
// - mem_we     out  1   registered write enable; only meaningful with mem_req
// - mem_addr   out  AW  registered address
// - mem_wdata  out  DW  registered write data
// - mem_rdata  in   DW  read data, sampled when mem_ready
// - mem_ready  in   1   memory completes the access this cycle
// - err        out  1   one-cycle pulse on a watchdog abort
// BEHAVIOUR
// - Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0,
//   dbg_rdata=0, dbg_ack=0, err=0; state=IDLE; watchdog count=0; last-grant=DBG.
// - States: IDLE, CPU, DBG.
// - IDLE:
//   - If any request is pending: pick a winner, register its we/addr/wdata onto mem_*,
//     set mem_req=1, and go to CPU or DBG.
//   - Otherwise stay in IDLE.
// - CPU/DBG:
//   - Each cycle with mem_ready=1 completes the access:
//     - Capture mem_rdata into the winner's rdata (loads; stores leave rdata unchanged).
//     - CPU: cpu_stall drops combinationally that same cycle.
//     - DBG: dbg_ack pulses the following cycle.
//     - Then mem_req=0 and return to IDLE. No back-to-back grant: one IDLE cycle per access.
//   - Minimum CPU access: request seen at cycle N -> mem_req at N+1 -> done at N+1 if
//     mem_ready; cpu_stall is high for at least cycle N.
// - Watchdog:
//   - Counts cycles in CPU/DBG without mem_ready.
//   - On the MAX_WAIT-th such cycle: abort, pulse err, complete the access with rdata=0,
//     return to IDLE.
//   - Counter width is $clog2(MAX_WAIT+1); it clears on completion.
// - mem_ready while in IDLE is ignored.
// - Simultaneous cpu_req and dbg_req in IDLE: winner is set by arbitration (CONFIGURATION).
// - A requester dropping its req mid-grant is illegal; the arbiter still completes the access.
// - Reset mid-access: the next edge forces IDLE and mem_req=0; the pending access is lost,
//   with no ack and no err.
// CONFIGURATION
// - DMEM_ARB_RR_EN undefined:
//   - Fixed priority, CPU over DBG.
//   - DBG is granted only when cpu_req=0 in IDLE.
// - DMEM_ARB_RR_EN defined:
//   - Round-robin. On a tie the winner is the port not granted last; last-grant updates
//     on every grant.
//   - Single requests are granted as without the macro.
// TESTING
// - CPU store addr 84 data 7, mem_ready 2 cycles after mem_req
//   -> mem_we=1, mem_addr=84, mem_wdata=7; cpu_stall high 3 cycles; err=0.
// - CPU load addr 80, mem_rdata=0x0000_0005 with mem_ready immediate
//   -> cpu_rdata=5 when cpu_stall falls; cpu_stall high exactly 1 cycle.
// - cpu_req and dbg_req raised together, 3 back-to-back pairs
//   -> no macro: CPU,CPU,CPU then DBG; with DMEM_ARB_RR_EN: CPU,DBG,CPU,DBG alternate.
// - DBG read addr 0x10, mem_ready never asserted, MAX_WAIT=16
//   -> err pulse on the 16th waiting cycle; dbg_ack next cycle with dbg_rdata=0; state IDLE.
// - reset asserted 1 cycle into a DBG access -> mem_req=0 next edge; no dbg_ack; no err;
//   a new cpu_req after reset is granted normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug and memory signals around dmem_arbiter.
// slave: the arbiter's view; master: the surrounding core/debug/memory view.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core MEM stage and a debug port,
// with a watchdog abort. Define DMEM_ARB_RR_EN for round-robin instead of CPU priority.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned WdW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StCpu, StDbg} state_e;

  state_e        state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          dbg_ack_q, dbg_ack_d;

  logic          dbg_req_eff, any_req, pick_dbg;
  logic          granted, wd_abort, done, cpu_done;
  logic [DW-1:0] rd_val;

  // The debug port still holds req during its ack cycle; ignore it so it is not re-granted.
  assign dbg_req_eff = bus.dbg_req & ~dbg_ack_q;
  assign any_req     = bus.cpu_req | dbg_req_eff;
  assign granted     = (state_q != StIdle);
  assign wd_abort    = granted & ~bus.mem_ready & (wd_q == WdW'(MAX_WAIT - 1));
  assign done        = granted & (bus.mem_ready | wd_abort);
  assign cpu_done    = (state_q == StCpu) & done;
  assign rd_val      = wd_abort ? '0 : bus.mem_rdata;

`ifdef DMEM_ARB_RR_EN
  logic last_dbg_q, last_dbg_d;

  assign last_dbg_d = (state_q == StIdle && any_req) ? pick_dbg : last_dbg_q;
  assign pick_dbg   = dbg_req_eff & (~bus.cpu_req | ~last_dbg_q);

  always_ff @(posedge clk) begin
    if (reset) last_dbg_q <= 1'b1;
    else       last_dbg_q <= last_dbg_d;
  end
`else
  assign pick_dbg = dbg_req_eff & ~bus.cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (any_req) state_d = pick_dbg ? StDbg : StCpu;
      StCpu, StDbg: if (done) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        wd_d = '0;
        if (any_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = pick_dbg ? bus.dbg_we    : bus.cpu_we;
          mem_addr_d  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
          mem_wdata_d = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
      end
      StCpu, StDbg: begin
        if (done) begin
          wd_d      = '0;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (state_q == StCpu) cpu_rdata_d = rd_val;
            else                  dbg_rdata_d = rd_val;
          end
          if (state_q == StDbg) dbg_ack_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // Load data bypasses the register so it is valid in the cycle the stall drops.
  assign bus.cpu_rdata = (cpu_done & ~mem_we_q) ? rd_val : cpu_rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.err       = wd_abort & ~reset;

endmodule
